// File: rtl/apb_req_master_pkg.sv
// Shared definitions for the APB request master: FSM state encoding and
// the read data returned on a timeout abort.
package apb_req_master_pkg;

  typedef logic [1:0] apb_state_t;

  localparam apb_state_t IDLE   = 2'd0;
  localparam apb_state_t SETUP  = 2'd1;
  localparam apb_state_t ACCESS = 2'd2;

  // Replicated to the data width at the point of use.
  localparam logic TIMEOUT_RDATA_BIT = 1'b0;

endpackage

// File: rtl/apb_req_timeout_cnt.sv
// ACCESS-phase wait counter; expired_o flags the wait cycle on which the
// count would reach TIMEOUT_CYCLES, so the master can abort on that edge.
module apb_req_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = inc_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/apb_req_master.sv
// Request/grant to APB master bridge, one transfer outstanding.
// Optional ACCESS timeout enabled by defining APB_REQ_MASTER_TIMEOUT_EN.
module apb_req_master
  import apb_req_master_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      r_valid_o,
  output logic [APB_DATA_WIDTH-1:0] r_rdata_o,
  output logic                      r_opc_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cfg
    $error("apb_req_master: TIMEOUT_CYCLES must be at least 1");
  end

  apb_state_t state_q, state_d;

  logic                      xfer_done;
  logic                      timeout_hit;
  logic                      pwrite_q;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [APB_DATA_WIDTH-1:0] pwdata_q;
  logic                      r_valid_q;
  logic                      r_opc_q;
  logic [APB_DATA_WIDTH-1:0] r_rdata_q;

  assign xfer_done = (state_q == ACCESS) && pready_i;

`ifdef APB_REQ_MASTER_TIMEOUT_EN
  logic cnt_clr;
  logic cnt_inc;

  // Counter restarts on the SETUP->ACCESS edge and counts only wait cycles.
  assign cnt_clr = (state_q == SETUP);
  assign cnt_inc = (state_q == ACCESS) && !pready_i;

  apb_req_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (cnt_clr),
    .inc_i    (cnt_inc),
    .expired_o(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_i) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready_i || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request fields are captured only on grant, so they hold through IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
    end else if (gnt_o) begin
      paddr_q  <= addr_i;
      pwrite_q <= we_i;
      pwdata_q <= wdata_i;
    end
  end

  // timeout_hit can only fire with pready_i low, so completion wins a tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_q <= 1'b0;
      r_opc_q   <= 1'b0;
      r_rdata_q <= '0;
    end else begin
      r_valid_q <= xfer_done || timeout_hit;
      if (xfer_done) begin
        r_opc_q   <= pslverr_i;
        r_rdata_q <= pwrite_q ? '0 : prdata_i;
      end else if (timeout_hit) begin
        r_opc_q   <= 1'b1;
        r_rdata_q <= {APB_DATA_WIDTH{TIMEOUT_RDATA_BIT}};
      end
    end
  end

  assign gnt_o     = (state_q == IDLE) && req_i;
  assign psel_o    = (state_q != IDLE);
  assign penable_o = (state_q == ACCESS);
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign r_valid_o = r_valid_q;
  assign r_opc_o   = r_opc_q;
  assign r_rdata_o = r_rdata_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Bench for apb_req_master: transaction-age reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_apb_req_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk_i     = 1'b0;
  logic          rst_ni    = 1'b0;
  logic          req_i     = 1'b0;
  logic          we_i      = 1'b0;
  logic [AW-1:0] addr_i    = '0;
  logic [DW-1:0] wdata_i   = '0;
  logic [DW-1:0] prdata_i  = '0;
  logic          pready_i  = 1'b0;
  logic          pslverr_i = 1'b0;
  logic          gnt_o, r_valid_o, r_opc_o, psel_o, penable_o, pwrite_o;
  logic [DW-1:0] r_rdata_o, pwdata_o;
  logic [AW-1:0] paddr_o;

  always #5 clk_i = ~clk_i;

  apb_req_master #(
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .addr_i   (addr_i),
    .we_i     (we_i),
    .wdata_i  (wdata_i),
    .r_valid_o(r_valid_o),
    .r_rdata_o(r_rdata_o),
    .r_opc_o  (r_opc_o),
    .psel_o   (psel_o),
    .penable_o(penable_o),
    .pwrite_o (pwrite_o),
    .paddr_o  (paddr_o),
    .pwdata_o (pwdata_o),
    .prdata_i (prdata_i),
    .pready_i (pready_i),
    .pslverr_i(pslverr_i)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dut_rv_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Reference model: age = cycles since the grant of the outstanding transfer
  // (0 = none); age 1 is the setup phase, age >= 2 the access phase.
  int            age      = 0;
  logic [AW-1:0] m_addr   = '0;
  logic          m_we     = 1'b0;
  logic [DW-1:0] m_wdata  = '0;
  logic          m_rvalid = 1'b0;
  logic [DW-1:0] m_rdata  = '0;
  logic          m_opc    = 1'b0;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      age      <= 0;
      m_addr   <= '0;
      m_we     <= 1'b0;
      m_wdata  <= '0;
      m_rvalid <= 1'b0;
      m_rdata  <= '0;
      m_opc    <= 1'b0;
    end else begin
      m_rvalid <= 1'b0;
      if (age == 0) begin
        if (req_i) begin
          age     <= 1;
          m_addr  <= addr_i;
          m_we    <= we_i;
          m_wdata <= wdata_i;
        end
      end else if (age >= 2 && pready_i) begin
        age      <= 0;
        m_rvalid <= 1'b1;
        m_rdata  <= m_we ? '0 : prdata_i;
        m_opc    <= pslverr_i;
      end
`ifdef APB_REQ_MASTER_TIMEOUT_EN
      else if (age >= 2 && (age - 1) == TO) begin
        age      <= 0;
        m_rvalid <= 1'b1;
        m_rdata  <= '0;
        m_opc    <= 1'b1;
      end
`endif
      else begin
        age <= age + 1;
      end
    end
  end

  always @(negedge clk_i) begin
    check("gnt_o",     gnt_o,     (age == 0) && req_i);
    check("psel_o",    psel_o,    age != 0);
    check("penable_o", penable_o, age >= 2);
    check("paddr_o",   paddr_o,   m_addr);
    check("pwrite_o",  pwrite_o,  m_we);
    check("pwdata_o",  pwdata_o,  m_wdata);
    check("r_valid_o", r_valid_o, m_rvalid);
    check("r_rdata_o", r_rdata_o, m_rdata);
    check("r_opc_o",   r_opc_o,   m_opc);
    if (r_valid_o === 1'b1) dut_rv_cnt <= dut_rv_cnt + 1;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int rv_base, gcount, seen, gcyc0;
    int gcyc[4];
    logic [DW-1:0] to_rdata;
    logic to_opc;

    // Reset state
    repeat (3) tick();
    check("rst_psel", psel_o, 1'b0);
    check("rst_penable", penable_o, 1'b0);
    check("rst_paddr", paddr_o, 32'h0);
    check("rst_rvalid", r_valid_o, 1'b0);
    check("rst_gnt", gnt_o, 1'b0);
    rst_ni = 1'b1;
    tick();

    // Zero-wait read
    addr_i = 32'h1A10_0004; we_i = 1'b0; prdata_i = 32'hCAFE_F00D;
    pready_i = 1'b1; pslverr_i = 1'b0; req_i = 1'b1;
    #1 check("rd_gnt_N", gnt_o, 1'b1);
    tick(); req_i = 1'b0;
    #1 check("rd_psel_N1", {psel_o, penable_o}, 2'b10);
    tick();
    #1 check("rd_psel_N2", {psel_o, penable_o}, 2'b11);
    check("rd_paddr", paddr_o, 32'h1A10_0004);
    tick();
    #1 check("rd_rvalid_N3", r_valid_o, 1'b1);
    check("rd_rdata", r_rdata_o, 32'hCAFE_F00D);
    check("rd_opc", r_opc_o, 1'b0);
    tick();
    #1 check("rd_rvalid_drop", r_valid_o, 1'b0);
    check("rd_rdata_hold", r_rdata_o, 32'hCAFE_F00D);

    // Write with 3 wait states; request inputs change after the grant
    pready_i = 1'b0; we_i = 1'b1; addr_i = 32'h0000_0040; wdata_i = 32'h1234_5678;
    req_i = 1'b1;
    #1 check("wr_gnt", gnt_o, 1'b1);
    tick(); req_i = 1'b0; addr_i = 32'hDEAD_BEEF; wdata_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      #1 check("wr_paddr_stable", paddr_o, 32'h0000_0040);
      check("wr_pwdata_stable", pwdata_o, 32'h1234_5678);
      check("wr_pwrite", pwrite_o, 1'b1);
      tick();
    end
    pready_i = 1'b1;
    #1 check("wr_access_last", {psel_o, penable_o}, 2'b11);
    tick();
    #1 check("wr_rvalid", r_valid_o, 1'b1);
    check("wr_rdata_zero", r_rdata_o, 32'h0);
    check("wr_opc", r_opc_o, 1'b0);
    tick();
    check("wr_paddr_idle_hold", paddr_o, 32'h0000_0040);

    // Slave error on a read
    we_i = 1'b0; addr_i = 32'h1A10_0008; prdata_i = 32'h0BAD_0BAD; pslverr_i = 1'b1;
    req_i = 1'b1;
    tick(); req_i = 1'b0;
    tick();
    tick(); pslverr_i = 1'b0;
    #1 check("err_rvalid", r_valid_o, 1'b1);
    check("err_opc", r_opc_o, 1'b1);
    check("err_rdata", r_rdata_o, 32'h0BAD_0BAD);
    tick();
    check("err_opc_hold", r_opc_o, 1'b1);

    // Back-to-back: req held for four grants
    rv_base = dut_rv_cnt; gcount = 0;
    addr_i = 32'h0000_0100; req_i = 1'b1; pready_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      if (gnt_o) begin
        if (gcount < 4) gcyc[gcount] = cyc;
        gcount++;
      end
      tick();
      if (gcount >= 4) req_i = 1'b0;
      addr_i   = 32'h0000_0100 + 32'(4 * gcount);
      prdata_i = 32'hA5A5_0000 + 32'(k);
    end
    check("b2b_grants", 32'(gcount), 32'd4);
    check("b2b_gap1", 32'(gcyc[1] - gcyc[0]), 32'd3);
    check("b2b_gap2", 32'(gcyc[2] - gcyc[0]), 32'd6);
    check("b2b_gap3", 32'(gcyc[3] - gcyc[0]), 32'd9);
    check("b2b_rvalids", 32'(dut_rv_cnt - rv_base), 32'd4);

    // Reset asserted during ACCESS
    pready_i = 1'b0; we_i = 1'b0; addr_i = 32'h0000_2000; req_i = 1'b1;
    tick(); req_i = 1'b0;
    tick();
    #1 check("rstmid_in_access", penable_o, 1'b1);
    #1 rst_ni = 1'b0;
    #1 check("rstmid_psel", {psel_o, penable_o}, 2'b00);
    check("rstmid_paddr", paddr_o, 32'h0);
    check("rstmid_rdata", r_rdata_o, 32'h0);
    check("rstmid_opc_valid", {r_opc_o, r_valid_o}, 2'b00);
    tick(); tick();
    rst_ni = 1'b1; pready_i = 1'b1;
    rv_base = dut_rv_cnt;
    repeat (6) tick();
    check("rstmid_no_rvalid", 32'(dut_rv_cnt - rv_base), 32'd0);

    // Slave never ready
    pready_i = 1'b0; we_i = 1'b0; addr_i = 32'h0000_3000; req_i = 1'b1;
    #1 check("to_gnt", gnt_o, 1'b1);
    gcyc0 = cyc; seen = -1; to_rdata = '1; to_opc = 1'b0;
    tick(); req_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (r_valid_o && seen < 0) begin
        seen = cyc - gcyc0; to_rdata = r_rdata_o; to_opc = r_opc_o;
      end
      tick();
    end
`ifdef APB_REQ_MASTER_TIMEOUT_EN
    check("to_latency", 32'(seen), 32'd6);
    check("to_opc", to_opc, 1'b1);
    check("to_rdata", to_rdata, 32'h0);
    check("to_idle_after", psel_o, 1'b0);
`else
    check("nto_no_rvalid", seen < 0, 1'b1);
    check("nto_still_access", {psel_o, penable_o}, 2'b11);
    pready_i = 1'b1; seen = -1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (r_valid_o && seen < 0) seen = k;
    end
    check("nto_completes", seen, 32'd0);
`endif

    pready_i = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
